sc_timer_ctrl: RTL and testbench

SC_TIMER_CTRL -- requirements
Module: SC_TIMER_CTRL

---
 rtl/sc_timer_ctrl.sv | 80 ++++++++
 tb/tb_sc_timer_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/sc_timer_ctrl.sv
// sc_timer_ctrl: sequences N periods of an external prescaler counter, pulsing tick per period and done per run.
// Build macro SC_TIMER_CTRL_AUTORELOAD_EN: DONE reloads the period count latched at start and reruns.
module sc_timer_ctrl #(
  parameter int PERIODS_WIDTH = 8
) (
  input  logic                     SC_TIMER_CTRL_CLOCK_50,
  input  logic                     SC_TIMER_CTRL_RESET_InLow,
  input  logic                     SC_TIMER_CTRL_start_InLow,
  input  logic                     SC_TIMER_CTRL_abort_InLow,
  input  logic [PERIODS_WIDTH-1:0] SC_TIMER_CTRL_periods_InBUS,
  input  logic                     SC_TIMER_CTRL_eoc_InLow,
  output logic                     SC_TIMER_CTRL_count_OutLow,
  output logic                     SC_TIMER_CTRL_tick_OutHigh,
  output logic                     SC_TIMER_CTRL_busy_OutHigh,
  output logic                     SC_TIMER_CTRL_done_OutHigh
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WRAP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [PERIODS_WIDTH-1:0] ONE = PERIODS_WIDTH'(1);
  logic [1:0] state_q, state_d;
  logic [PERIODS_WIDTH-1:0] rem_q, rem_d;
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
  logic [PERIODS_WIDTH-1:0] per_q, per_d;
`endif
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
    per_d   = per_q;
`endif
    if (!SC_TIMER_CTRL_abort_InLow) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (!SC_TIMER_CTRL_start_InLow) begin
          rem_d   = SC_TIMER_CTRL_periods_InBUS;
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
          per_d   = SC_TIMER_CTRL_periods_InBUS;
`endif
          state_d = (SC_TIMER_CTRL_periods_InBUS == '0) ? DONE : RUN;
        end
        RUN: state_d = SC_TIMER_CTRL_eoc_InLow ? RUN : WRAP;
        // saturating decrement keeps the remaining count from wrapping below zero
        WRAP: begin
          rem_d   = (rem_q != '0) ? rem_q - ONE : '0;
          state_d = (rem_q <= ONE) ? DONE : RUN;
        end
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
        DONE: begin
          rem_d   = per_q;
          state_d = (per_q == '0) ? IDLE : RUN;
        end
`else
        DONE: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge SC_TIMER_CTRL_CLOCK_50) begin
    if (!SC_TIMER_CTRL_RESET_InLow) begin
      state_q <= IDLE;
      rem_q   <= '0;
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
      per_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
      per_q   <= per_d;
`endif
    end
  end
  assign SC_TIMER_CTRL_count_OutLow = (state_q != RUN);
  assign SC_TIMER_CTRL_tick_OutHigh = (state_q == WRAP);
  assign SC_TIMER_CTRL_busy_OutHigh = (state_q == RUN) || (state_q == WRAP);
  assign SC_TIMER_CTRL_done_OutHigh = (state_q == DONE);
endmodule

// File: tb/tb_sc_timer_ctrl.sv
// tb_sc_timer_ctrl: directed and random stimulus against a schedule-based model, with a 4-bit external prescaler.
module tb_sc_timer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_n = 1'b1;
  logic abort_n = 1'b1;
  logic [7:0] periods = 8'd0;
  logic eoc_n;
  logic count_n, tick, busy, done;
  logic noise = 1'b1;
  logic [3:0] cnt = 4'd0;
  logic [3:0] cnt_nxt;
  int tests = 0;
  int fails = 0;
  int tick_seen = 0;
  int done_seen = 0;
  bit m_act = 1'b0;
  int m_off = 0;
  int m_p = 0;

  always #5 clk = ~clk;

  // prescaler reports the MSB of the value it is about to take, so one period is 8 RUN cycles
  assign cnt_nxt = count_n ? 4'd0 : cnt + 4'd1;
  assign eoc_n = count_n ? noise : ~cnt_nxt[3];
  always @(posedge clk) cnt <= cnt_nxt;

  sc_timer_ctrl #(.PERIODS_WIDTH(8)) dut (
    .SC_TIMER_CTRL_CLOCK_50(clk),
    .SC_TIMER_CTRL_RESET_InLow(rst_n),
    .SC_TIMER_CTRL_start_InLow(start_n),
    .SC_TIMER_CTRL_abort_InLow(abort_n),
    .SC_TIMER_CTRL_periods_InBUS(periods),
    .SC_TIMER_CTRL_eoc_InLow(eoc_n),
    .SC_TIMER_CTRL_count_OutLow(count_n),
    .SC_TIMER_CTRL_tick_OutHigh(tick),
    .SC_TIMER_CTRL_busy_OutHigh(busy),
    .SC_TIMER_CTRL_done_OutHigh(done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic s_n, input logic a_n, input logic r_n, input logic [7:0] p, input string tag);
    logic e_busy, e_done, e_tick, e_count;
    @(negedge clk);
    start_n = s_n;
    abort_n = a_n;
    rst_n   = r_n;
    periods = p;
    noise   = 1'($urandom);
    @(posedge clk);
    if (!r_n || !a_n) m_act = 1'b0;
    else if (!m_act) begin
      if (!s_n) begin
        m_act = 1'b1;
        m_off = 0;
        m_p   = int'(p);
      end
    end else begin
      m_off++;
`ifdef SC_TIMER_CTRL_AUTORELOAD_EN
      if (m_p == 0) m_act = 1'b0;
      else if (m_off > 9 * m_p) m_off = 0;
`else
      if (m_off > 9 * m_p) m_act = 1'b0;
`endif
    end
    #1;
    e_busy  = m_act && (m_off < 9 * m_p);
    e_done  = m_act && (m_off == 9 * m_p);
    e_tick  = e_busy && (m_off % 9 == 8);
    e_count = !(e_busy && (m_off % 9 != 8));
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".tick"}, tick, e_tick);
    chk({tag, ".count"}, count_n, e_count);
    tick_seen += int'(tick);
    done_seen += int'(done);
  endtask

  initial begin
    step(1, 1, 0, 8'd0, "reset");
    step(1, 1, 0, 8'd0, "reset");
    for (int i = 0; i < 4; i++) step(1, 1, 1, 8'd0, "idle");
    step(0, 1, 1, 8'd3, "p3_start");
    for (int i = 0; i < 32; i++) step(1, 1, 1, 8'd0, "p3_run");
    step(1, 1, 1, 8'd0, "p3_idle");
    step(0, 1, 1, 8'd0, "p0_start");
    for (int i = 0; i < 4; i++) step(1, 1, 1, 8'd9, "p0_after");
    step(0, 1, 1, 8'd5, "p5_start");
    for (int i = 0; i < 17; i++) step(1, 1, 1, 8'd5, "p5_run");
    step(1, 0, 1, 8'd5, "p5_abort");
    tick_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) step(1, 1, 1, 8'd5, "p5_after");
    chk("p5_no_tick", tick_seen != 0, 1'b0);
    chk("p5_no_done", done_seen != 0, 1'b0);
    tick_seen = 0;
    done_seen = 0;
    step(0, 1, 1, 8'd2, "p2_start");
    for (int i = 0; i < 18; i++) step(0, 1, 1, (i < 5) ? 8'd2 : 8'd7, "p2_held");
    chk("p2_ticks", tick_seen == 2, 1'b1);
    chk("p2_dones", done_seen == 1, 1'b1);
    step(1, 0, 1, 8'd0, "p2_abort");
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0), ($urandom_range(0, 149) != 0),
           8'($urandom_range(0, 4)), "rand");
    step(1, 1, 0, 8'd0, "final_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
